score_display_scan: RTL and testbench
=====================================

# score_display_scan

Parametrised multiplexed seven-segment score display, the next generation of the fixed 4-digit score display fed by the game FSM's score output. A sequential double-dabble engine converts a binary score to BCD. A prescaled scanner drives DIGITS common-anode digits. The block adds leading-zero blanking, an overflow indication and a best-score register with a display select. It sits between `wechat_jump_fsm.o_score` and the board segment/anode pins.

## Interface
- `SCORE_W`, default 10: score width in bits (≥ 1).
- `DIGITS`, default 4: number of displayed digits (1–8).
- `SCAN_DIV`, default 17: prescaler width; each digit is lit for 2^SCAN_DIV cycles.
- `BLANK_LZ`, default 1: 1 enables leading-zero blanking.
- `ACTIVE_LOW`, default 1: 1 makes segments and anodes active-low; 0 makes them active-high.

Ports:
- `clk`  in  1  system clock. One clock domain; everything is sampled on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `i_score`  in  SCORE_W  current score (binary), level-sampled.
- `i_show_best`  in  1  1 displays the best score; 0 displays the current score.
- `o_segment`  out  8  segment pattern `{dp,g,f,e,d,c,b,a}`; dp is always off.
- `o_segment_an`  out  DIGITS  one-hot digit select; bit 0 is the least significant digit.
- `o_busy`  out  1  high while a conversion is in progress.
- `o_best`  out  SCORE_W  highest score committed since reset (binary).

## Operation
- Internal BCD width is (DIGITS+1) nibbles. The extra top nibble detects overflow.
- Registers:
  - `shadow`: last converted binary value.
  - `cur_bcd`: current score in BCD, plus its overflow flag.
  - `best_bcd`: best score in BCD, plus its overflow flag.
  - `o_best`.
- Converter FSM has three states:
  - **IDLE**: if `i_score != shadow`, latch `i_score` into the work register, clear the BCD accumulator, set `o_busy`, and go to SHIFT.
  - **SHIFT**: runs exactly SCORE_W cycles. Each cycle, add 3 to every nibble ≥ 5, then shift `{bcd,work}` left by 1. Then go to COMMIT.
  - **COMMIT**: one cycle.
    - `shadow ← latched value`.
    - `cur_bcd ← accumulator`. Overflow = top nibble ≠ 0.
    - If latched value > `o_best` (unsigned), update `o_best` and `best_bcd` in the same cycle.
    - Clear `o_busy` and return to IDLE.
- A change in `i_score` during SHIFT or COMMIT does not disturb the conversion. IDLE sees the mismatch on the next cycle and restarts.
- Scanner:
  - The prescaler counts 0..2^SCAN_DIV−1 and wraps.
  - On wrap, the digit index advances from 0 to DIGITS−1, then back to 0.
  - Registered outputs show the selected nibble from `cur_bcd`, or from `best_bcd` when `i_show_best` = 1.
- Decode, shown active-high; the pattern is inverted when ACTIVE_LOW = 1:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Dash = 0x40. Blank = 0x00.
- Digit priority, highest first:
  1. If the selected value's overflow flag is set, every digit shows a dash.
  2. If BLANK_LZ = 1, digit i > 0 is blank when nibbles i..DIGITS−1 are all zero.
  3. Digit 0 always shows its value, so a score of 0 displays "0".
- The anode of the selected digit is active. All other anodes are inactive.

## Timing
- Reset values:
  - Converter state IDLE; `o_busy` = 0; `o_best` = 0.
  - `shadow`, `cur_bcd` and `best_bcd` = 0; overflow flags = 0.
  - Prescaler and digit index = 0.
  - `o_segment` = blank pattern; `o_segment_an` = all inactive.
- First clock after reset release: `o_segment_an` selects digit 0 and `o_segment` shows "0". No conversion runs, because `i_score` = 0 matches `shadow`.
- Conversion latency: `i_score` changes at cycle t; t+1 latches it and `o_busy` rises; SCORE_W SHIFT cycles follow; COMMIT is at cycle t+SCORE_W+1; the new digits appear on `o_segment` from cycle t+SCORE_W+2. `o_busy` is high for SCORE_W+1 cycles.
- Back-to-back changes: each conversion runs to completion. The next one starts from IDLE, one cycle after COMMIT.
- `i_show_best` affects `o_segment` one cycle after it changes. The scan position is unaffected.
- Output registration: `o_segment` and `o_segment_an` are registered and change together, one cycle after the digit index changes. There is no glitch between them.
- Reset asserted mid-conversion: the conversion aborts immediately and all values return to their reset values. After release, a nonzero `i_score` triggers a fresh conversion.
- `o_best` compares only committed values. A score that drops never lowers `o_best`.

## Test plan
- Reset, then `i_score` = 0 with SCAN_DIV = 2, DIGITS = 4 (ACTIVE_LOW = 1) -> anodes cycle 1110, 1101, 1011, 0111, each held 4 cycles; segments 0xC0 on digit 0 and 0xFF on digits 1–3.
- `i_score` = 1023 at cycle t -> `o_busy` high for cycles t+1..t+11; from t+12 the digits show 3, 2, 0, 1 (0xB0, 0xA4, 0xC0, 0xF9); `o_best` = 1023.
- `i_score` = 1000, then 5 once idle -> digits show 5 with digits 1–3 blank; `o_best` stays 1000; `i_show_best` = 1 shows 0, 0, 0, 1.
- SCORE_W = 14, DIGITS = 3, `i_score` = 1000 -> all three digits show a dash (0xBF); `i_score` = 999 -> digits show 9, 9, 9.
- Change `i_score` from 7 to 8 two cycles into a conversion -> 7 commits first; 8 commits SCORE_W+2 cycles after that commit; `o_busy` drops for exactly one cycle in between.
- Assert `rst` mid-SHIFT -> `o_busy` = 0, anodes all inactive, `o_best` = 0; after release with `i_score` = 42, "42" appears SCORE_W+2 cycles later.

Source files
------------

// File: rtl/score_display_scan.sv
// rtl/score_display_scan.sv - binary score to multiplexed seven-segment display with best-score tracking
// Sequential double-dabble converter, prescaled digit scanner, blanking and overflow dashes.
module score_display_scan #(
  parameter int SCORE_W    = 10,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 17,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_show_best,
  output logic [7:0]         o_segment,
  output logic [DIGITS-1:0]  o_segment_an,
  output logic               o_busy,
  output logic [SCORE_W-1:0] o_best
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int DSP_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t             state, state_d;
  logic [SCORE_W-1:0] shadow, latched, work;
  logic [BCD_W-1:0]   acc, acc_adj;
  logic               acc_ovf;
  logic [CNT_W-1:0]   bit_cnt;

  logic [DSP_W-1:0]   cur_bcd, best_bcd, cur_bcd_d, best_bcd_d;
  logic               cur_ovf, best_ovf, cur_ovf_d, best_ovf_d;
  logic [SCORE_W-1:0] best_d;

  logic [SCAN_DIV-1:0] prescale;
  logic [IDX_W-1:0]    digit_idx;

  logic [DSP_W-1:0]    sel_bcd;
  logic                sel_ovf;
  logic [3:0]          nib;
  logic                upper_zero;
  logic [7:0]          pat;
  logic [DIGITS-1:0]   an_hot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (i_score != shadow) state_d = S_SHIFT;
      S_SHIFT:  if (bit_cnt == CNT_W'(SCORE_W - 1)) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int n = 0; n < DIGITS + 1; n++) begin
      if (acc[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
    end
  end

  // Commit results are computed here so the display picks them up on the same edge they are stored.
  always_comb begin
    cur_bcd_d  = cur_bcd;
    cur_ovf_d  = cur_ovf;
    best_d     = o_best;
    best_bcd_d = best_bcd;
    best_ovf_d = best_ovf;
    if (state == S_COMMIT) begin
      cur_bcd_d = acc[DSP_W-1:0];
      cur_ovf_d = acc_ovf | (acc[BCD_W-1 -: 4] != 4'd0);
      if (latched > o_best) begin
        best_d     = latched;
        best_bcd_d = cur_bcd_d;
        best_ovf_d = cur_ovf_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      latched  <= '0;
      work     <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      bit_cnt  <= '0;
      o_busy   <= 1'b0;
      cur_bcd  <= '0;
      cur_ovf  <= 1'b0;
      best_bcd <= '0;
      best_ovf <= 1'b0;
      o_best   <= '0;
    end else begin
      cur_bcd  <= cur_bcd_d;
      cur_ovf  <= cur_ovf_d;
      best_bcd <= best_bcd_d;
      best_ovf <= best_ovf_d;
      o_best   <= best_d;
      case (state)
        S_IDLE: begin
          if (i_score != shadow) begin
            latched <= i_score;
            work    <= i_score;
            acc     <= '0;
            acc_ovf <= 1'b0;
            bit_cnt <= '0;
            o_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Any bit pushed out of the top nibble is also overflow.
          acc     <= {acc_adj[BCD_W-2:0], work[SCORE_W-1]};
          acc_ovf <= acc_ovf | acc_adj[BCD_W-1];
          work    <= work << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        S_COMMIT: begin
          shadow <= latched;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale  <= '0;
      digit_idx <= '0;
    end else begin
      prescale <= prescale + SCAN_DIV'(1);
      if (&prescale) begin
        if (digit_idx == IDX_W'(DIGITS - 1)) digit_idx <= '0;
        else                                 digit_idx <= digit_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    sel_bcd    = i_show_best ? best_bcd_d : cur_bcd_d;
    sel_ovf    = i_show_best ? best_ovf_d : cur_ovf_d;
    nib        = sel_bcd[{digit_idx, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(digit_idx) && sel_bcd[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    pat = 8'h00;
    if (sel_ovf) begin
      pat = 8'h40;
    end else if (BLANK_LZ != 0 && digit_idx != '0 && upper_zero) begin
      pat = 8'h00;
    end else begin
      case (nib)
        4'd0: pat = 8'h3F;
        4'd1: pat = 8'h06;
        4'd2: pat = 8'h5B;
        4'd3: pat = 8'h4F;
        4'd4: pat = 8'h66;
        4'd5: pat = 8'h6D;
        4'd6: pat = 8'h7D;
        4'd7: pat = 8'h07;
        4'd8: pat = 8'h7F;
        4'd9: pat = 8'h6F;
        default: pat = 8'h40;
      endcase
    end
    an_hot = DIGITS'(1) << digit_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_segment    <= (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
      o_segment_an <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      o_segment    <= (ACTIVE_LOW != 0) ? ~pat : pat;
      o_segment_an <= (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// tb/tb_score_display_scan.sv - directed self-checking bench for score_display_scan
// Instance a: 10-bit score, 4 digits. Instance b: 14-bit score, 3 digits (overflow).
module tb_score_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  score_a;
  logic        show_a;
  logic [7:0]  seg_a;
  logic [3:0]  an_a;
  logic        busy_a;
  logic [9:0]  best_a;
  logic [13:0] score_b;
  logic        show_b;
  logic [7:0]  seg_b;
  logic [2:0]  an_b;
  logic        busy_b;
  logic [13:0] best_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  score_display_scan #(.SCORE_W(10), .DIGITS(4), .SCAN_DIV(2), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .i_score(score_a), .i_show_best(show_a),
    .o_segment(seg_a), .o_segment_an(an_a), .o_busy(busy_a), .o_best(best_a)
  );

  score_display_scan #(.SCORE_W(14), .DIGITS(3), .SCAN_DIV(2), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .i_score(score_b), .i_show_best(show_b),
    .o_segment(seg_b), .o_segment_an(an_b), .o_busy(busy_b), .o_best(best_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic seg_at(input int which, input int d, output logic [7:0] seg);
    logic [7:0] hot;
    logic [7:0] want;
    bit found;
    found = 1'b0;
    seg   = 8'h00;
    want  = 8'd1 << d;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      hot = (which != 0) ? {5'b0, ~an_b} : {4'b0, ~an_a};
      if (hot == want) begin
        found = 1'b1;
        seg   = (which != 0) ? seg_b : seg_a;
      end
    end
    if (!found) check("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_digits(input int which, input string tag, input logic [31:0] exp);
    logic [7:0] s;
    for (int d = 0; d < ((which != 0) ? 3 : 4); d++) begin
      seg_at(which, d, s);
      check($sformatf("%s_d%0d", tag, d), {24'd0, s}, {24'd0, exp[8*d +: 8]});
    end
  endtask

  task automatic wait_idle(input int which);
    bit done;
    done = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (((which != 0) ? busy_b : busy_a) == 1'b0) done = 1'b1;
    end
    if (!done) check("busy_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] digit_exp(input logic [3:0] an, input logic [31:0] exp);
    case (an)
      4'b1110: return exp[7:0];
      4'b1101: return exp[15:8];
      4'b1011: return exp[23:16];
      4'b0111: return exp[31:24];
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    logic [3:0] tmp;
    logic [3:0] ean;
    int n;
    rst = 1'b1; score_a = '0; show_a = 1'b0; score_b = '0; show_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_seg", {24'd0, seg_a}, 32'hFF);
    check("rst_an", {28'd0, an_a}, 32'hF);
    check("rst_an_b", {29'd0, an_b}, 32'h7);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_best", {22'd0, best_a}, 32'd0);
    rst = 1'b0;

    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      tmp = 4'b0001 << (c / 4);
      ean = ~tmp;
      check($sformatf("scan_an_%0d", c), {28'd0, an_a}, {28'd0, ean});
      check($sformatf("scan_seg_%0d", c), {24'd0, seg_a}, (c < 4) ? 32'hC0 : 32'hFF);
      check($sformatf("scan_busy_%0d", c), {31'd0, busy_a}, 32'd0);
    end

    score_a = 10'd1000;
    wait_idle(0);
    check("best_1000", {22'd0, best_a}, 32'd1000);
    check_digits(0, "v1000", 32'hF9C0C0C0);
    score_a = 10'd5;
    wait_idle(0);
    check_digits(0, "v5", 32'hFFFFFF92);
    check("best_keep", {22'd0, best_a}, 32'd1000);
    show_a = 1'b1;
    check_digits(0, "show_best", 32'hF9C0C0C0);
    show_a = 1'b0;
    @(negedge clk);

    score_a = 10'd1023;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("lat_busy_%0d", k), {31'd0, busy_a}, 32'd1);
    end
    @(negedge clk);
    check("lat_busy_low", {31'd0, busy_a}, 32'd0);
    check("lat_seg_first", {24'd0, seg_a}, {24'd0, digit_exp(an_a, 32'hF9C0A4B0)});
    check_digits(0, "v1023", 32'hF9C0A4B0);
    check("best_1023", {22'd0, best_a}, 32'd1023);

    score_a = 10'd7;
    @(negedge clk);
    check("b2b_busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    score_a = 10'd8;
    wait_idle(0);
    check("gap_seg7", {24'd0, seg_a}, {24'd0, digit_exp(an_a, 32'hFFFFFFF8)});
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (!busy_a) n = i;
    end
    check("b2b_commit_gap", n, 32'd12);
    check_digits(0, "v8", 32'hFFFFFF80);

    score_b = 14'd1000;
    wait_idle(1);
    check_digits(1, "ovf", 32'h00BFBFBF);
    check("best_b", {18'd0, best_b}, 32'd1000);
    score_b = 14'd999;
    wait_idle(1);
    check_digits(1, "v999", 32'h00909090);

    score_a = 10'd42;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check("mid_rst_an", {28'd0, an_a}, 32'hF);
    check("mid_rst_best", {22'd0, best_a}, 32'd0);
    check("mid_rst_seg", {24'd0, seg_a}, 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      @(negedge clk);
      if (i > 1 && !busy_a) n = i;
    end
    check("rst_conv_lat", n, 32'd12);
    check_digits(0, "v42", 32'hFFFF99A4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
